// File: rtl/axi_ad9364_pkg.sv
// Shared constants for the AD9364 DAC test-pattern generator: pattern mode
// encodings, PRBS15 polynomial/seed and the valid cadence for each channel config.
package axi_ad9364_pkg;

  // Pattern select encodings
  localparam logic [1:0] MODE_ALT  = 2'b00;
  localparam logic [1:0] MODE_RAMP = 2'b01;
  localparam logic [1:0] MODE_PRBS = 2'b10;
  localparam logic [1:0] MODE_ZERO = 2'b11;

  // PRBS15 generator, polynomial x^15 + x^14 + 1, all-ones seed
  localparam int                    LFSR_WIDTH = 15;
  localparam logic [LFSR_WIDTH-1:0] LFSR_SEED  = 15'h7FFF;

  // Clocks per dac_valid: 1R1T interleaves two rails, 2R2T four
  localparam int PERIOD_1R1T = 2;
  localparam int PERIOD_2R2T = 4;

  // Alternating-pattern half currently being emitted
  typedef enum logic {
    SEL_A = 1'b0,
    SEL_B = 1'b1
  } ab_sel_e;

  function automatic int cadence_period(input int num_channels);
    return (num_channels == 2) ? PERIOD_2R2T : PERIOD_1R1T;
  endfunction

  // One LFSR step: shift toward the MSB, feedback from taps 15 and 14
  function automatic logic [LFSR_WIDTH-1:0] lfsr15_step(input logic [LFSR_WIDTH-1:0] s);
    return {s[LFSR_WIDTH-2:0], s[14] ^ s[13]};
  endfunction

endpackage

// File: rtl/axi_ad9364_lfsr15.sv
// PRBS15 generator. The state is the sample source; it steps only when advance is set.
module axi_ad9364_lfsr15
  import axi_ad9364_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  advance,
  output logic [LFSR_WIDTH-1:0] state
);

  logic [LFSR_WIDTH-1:0] state_q;
  logic [LFSR_WIDTH-1:0] state_d;

  // Step the polynomial only when a PRBS sample is consumed
  always_comb begin
    state_d = state_q;
    if (advance) begin
      state_d = lfsr15_step(state_q);
    end
  end

  // State register, seeded on reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LFSR_SEED;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

endmodule

// File: rtl/axi_ad9364_dac_pattern_gen.sv
// AD9364 DAC test-pattern source. A phase counter sets the dac_valid cadence
// (every 2nd clk for 1R1T, every 4th for 2R2T); on each valid one sample of
// the selected pattern (alternating A/B, ramp, PRBS15 or zero) is registered.
module axi_ad9364_dac_pattern_gen
  import axi_ad9364_pkg::*;
#(
  parameter int                    DATA_WIDTH   = 12,
  parameter int                    NUM_CHANNELS = 1,
  parameter logic [DATA_WIDTH-1:0] PAT_A_I      = 12'o2064,
  parameter logic [DATA_WIDTH-1:0] PAT_A_Q      = 12'o1753,
  parameter logic [DATA_WIDTH-1:0] PAT_B_I      = 12'o4402,
  parameter logic [DATA_WIDTH-1:0] PAT_B_Q      = 12'o1337
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [1:0]            mode,
  input  logic                  pat_wr,
  input  logic [DATA_WIDTH-1:0] pat_a_i,
  input  logic [DATA_WIDTH-1:0] pat_a_q,
  input  logic [DATA_WIDTH-1:0] pat_b_i,
  input  logic [DATA_WIDTH-1:0] pat_b_q,
  output logic                  dac_valid,
  output logic [DATA_WIDTH-1:0] dac_data_i1,
  output logic [DATA_WIDTH-1:0] dac_data_q1,
  output logic [DATA_WIDTH-1:0] dac_data_i2,
  output logic [DATA_WIDTH-1:0] dac_data_q2,
  output logic                  dac_r1_mode,
  output logic [31:0]           sample_count
);

  typedef logic [DATA_WIDTH-1:0] sample_t;

  localparam logic [1:0] PHASE_LAST = 2'(cadence_period(NUM_CHANNELS) - 1);

  // Pattern register file, packed as {B_Q, B_I, A_Q, A_I}
  localparam int PAT_NUM = 4;
  localparam int IDX_A_I = 0;
  localparam int IDX_A_Q = 1;
  localparam int IDX_B_I = 2;
  localparam int IDX_B_Q = 3;
  localparam logic [PAT_NUM-1:0][DATA_WIDTH-1:0] PAT_RESET = {PAT_B_Q, PAT_B_I, PAT_A_Q, PAT_A_I};

  logic [PAT_NUM-1:0][DATA_WIDTH-1:0] pat_in;
  logic [PAT_NUM-1:0][DATA_WIDTH-1:0] pat_q;
  logic [PAT_NUM-1:0][DATA_WIDTH-1:0] pat_d;

  logic [1:0]  phase_q, phase_d;
  logic        valid_q, valid_d;
  sample_t     i1_q, i1_d;
  sample_t     q1_q, q1_d;
  sample_t     ramp_q, ramp_d;
  ab_sel_e     sel_q, sel_d;
  logic [31:0] count_q, count_d;

  logic                  fire;
  logic                  lfsr_adv;
  logic [LFSR_WIDTH-1:0] lfsr_state;
  logic                  lfsr_unused;
  sample_t               smp_i;
  sample_t               smp_q;

  assign pat_in = {pat_b_q, pat_b_i, pat_a_q, pat_a_i};

  // All four pattern registers load together on pat_wr
  for (genvar gi = 0; gi < PAT_NUM; gi++) begin : g_pat
    assign pat_d[gi] = pat_wr ? pat_in[gi] : pat_q[gi];
  end

  // A sample is issued whenever the running phase counter sits at zero
  assign fire     = enable && (phase_q == 2'd0);
  assign lfsr_adv = fire && (mode == MODE_PRBS);

  axi_ad9364_lfsr15 u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .advance (lfsr_adv),
    .state   (lfsr_state)
  );

  // Bits above DATA_WIDTH never reach the outputs
  assign lfsr_unused = ^lfsr_state;

  // Phase runs only while enabled; dropping enable parks it at zero
  always_comb begin
    phase_d = 2'd0;
    if (enable && (phase_q != PHASE_LAST)) begin
      phase_d = phase_q + 2'd1;
    end
  end

  // Candidate sample for the selected pattern, taken from current generator state
  always_comb begin
    smp_i = '0;
    smp_q = '0;
    case (mode)
      MODE_ALT: begin
        smp_i = (sel_q == SEL_B) ? pat_q[IDX_B_I] : pat_q[IDX_A_I];
        smp_q = (sel_q == SEL_B) ? pat_q[IDX_B_Q] : pat_q[IDX_A_Q];
      end
      MODE_RAMP: begin
        smp_i = ramp_q;
        smp_q = ~ramp_q;
      end
      MODE_PRBS: begin
        smp_i = lfsr_state[DATA_WIDTH-1:0];
        smp_q = ~lfsr_state[DATA_WIDTH-1:0];
      end
      default: begin
        smp_i = '0;
        smp_q = '0;
      end
    endcase
  end

  // Outputs and per-mode state move only on a valid; each generator steps only in its own mode
  always_comb begin
    valid_d = fire;
    i1_d    = i1_q;
    q1_d    = q1_q;
    sel_d   = sel_q;
    ramp_d  = ramp_q;
    count_d = count_q;
    if (fire) begin
      i1_d    = smp_i;
      q1_d    = smp_q;
      count_d = count_q + 32'd1;
      if (mode == MODE_ALT) begin
        sel_d = (sel_q == SEL_A) ? SEL_B : SEL_A;
      end
      if (mode == MODE_RAMP) begin
        ramp_d = ramp_q + sample_t'(1);
      end
    end
  end

  // State registers; reset beats both enable and pat_wr
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= 2'd0;
      valid_q <= 1'b0;
      i1_q    <= '0;
      q1_q    <= '0;
      sel_q   <= SEL_A;
      ramp_q  <= '0;
      count_q <= 32'd0;
      pat_q   <= PAT_RESET;
    end else begin
      phase_q <= phase_d;
      valid_q <= valid_d;
      i1_q    <= i1_d;
      q1_q    <= q1_d;
      sel_q   <= sel_d;
      ramp_q  <= ramp_d;
      count_q <= count_d;
      pat_q   <= pat_d;
    end
  end

  assign dac_valid    = valid_q;
  assign dac_data_i1  = i1_q;
  assign dac_data_q1  = q1_q;
  assign sample_count = count_q;
  assign dac_r1_mode  = (NUM_CHANNELS == 1);

  // Second channel mirrors the first with rails swapped; silent in 1R1T
  if (NUM_CHANNELS == 2) begin : g_ch2
    assign dac_data_i2 = q1_q;
    assign dac_data_q2 = i1_q;
  end else begin : g_ch1
    assign dac_data_i2 = '0;
    assign dac_data_q2 = '0;
  end

endmodule

// File: tb/tb_axi_ad9364_dac_pattern_gen.sv
// Bench for the DAC pattern generator: a 1R1T instance checked every clock
// against a behavioural model, plus a 2R2T instance for the four-clock cadence.
module tb_axi_ad9364_dac_pattern_gen;

  localparam logic [11:0] DEF_A_I = 12'o2064;
  localparam logic [11:0] DEF_A_Q = 12'o1753;
  localparam logic [11:0] DEF_B_I = 12'o4402;
  localparam logic [11:0] DEF_B_Q = 12'o1337;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 1R1T instance
  logic        rst, enable, pat_wr;
  logic [1:0]  mode;
  logic [11:0] pat_a_i, pat_a_q, pat_b_i, pat_b_q;
  logic        dac_valid, dac_r1_mode;
  logic [11:0] dac_data_i1, dac_data_q1, dac_data_i2, dac_data_q2;
  logic [31:0] sample_count;

  // 2R2T instance
  logic        rst2, en2;
  logic [1:0]  mode2;
  logic [11:0] zero12 = 12'd0;
  logic        pat_wr2 = 1'b0;
  logic        v2, r1m2;
  logic [11:0] i1_2, q1_2, i2_2, q2_2;
  logic [31:0] cnt2;

  int total = 0;
  int bad   = 0;

  // Behavioural model of the 1R1T instance
  int          m_run;      // clocks since enable was last sampled high
  bit          m_use_b;
  int          m_ramp;
  int          m_lfsr;
  logic [11:0] m_pat [4];
  logic        e_valid;
  logic [11:0] e_i1, e_q1;
  logic [31:0] e_cnt;

  wire [80:0] dut1_obs = {dac_valid, dac_data_i1, dac_data_q1, dac_data_i2, dac_data_q2, sample_count};
  wire [80:0] exp1     = {e_valid, e_i1, e_q1, 24'd0, e_cnt};

  axi_ad9364_dac_pattern_gen #(.DATA_WIDTH(12), .NUM_CHANNELS(1)) dut1 (
    .clk(clk), .rst(rst), .enable(enable), .mode(mode), .pat_wr(pat_wr),
    .pat_a_i(pat_a_i), .pat_a_q(pat_a_q), .pat_b_i(pat_b_i), .pat_b_q(pat_b_q),
    .dac_valid(dac_valid), .dac_data_i1(dac_data_i1), .dac_data_q1(dac_data_q1),
    .dac_data_i2(dac_data_i2), .dac_data_q2(dac_data_q2),
    .dac_r1_mode(dac_r1_mode), .sample_count(sample_count)
  );

  axi_ad9364_dac_pattern_gen #(.DATA_WIDTH(12), .NUM_CHANNELS(2)) dut2 (
    .clk(clk), .rst(rst2), .enable(en2), .mode(mode2), .pat_wr(pat_wr2),
    .pat_a_i(zero12), .pat_a_q(zero12), .pat_b_i(zero12), .pat_b_q(zero12),
    .dac_valid(v2), .dac_data_i1(i1_2), .dac_data_q1(q1_2),
    .dac_data_i2(i2_2), .dac_data_q2(q2_2),
    .dac_r1_mode(r1m2), .sample_count(cnt2)
  );

  function automatic bit will_fire();
    return !rst && enable && (m_run % 2 == 0);
  endfunction

  // One clock: model consumes the inputs present at the edge, outputs sampled 1 unit later
  task automatic tick();
    bit fire;
    @(posedge clk);
    if (rst) begin
      m_run = 0; m_use_b = 0; m_ramp = 0; m_lfsr = 32'h7fff;
      m_pat[0] = DEF_A_I; m_pat[1] = DEF_A_Q; m_pat[2] = DEF_B_I; m_pat[3] = DEF_B_Q;
      e_valid = 0; e_i1 = 0; e_q1 = 0; e_cnt = 0;
    end else begin
      fire = enable && (m_run % 2 == 0);
      m_run = enable ? m_run + 1 : 0;
      e_valid = fire;
      if (fire) begin
        case (mode)
          2'd0: begin
            e_i1 = m_use_b ? m_pat[2] : m_pat[0];
            e_q1 = m_use_b ? m_pat[3] : m_pat[1];
            m_use_b = !m_use_b;
          end
          2'd1: begin
            e_i1 = 12'(m_ramp);
            e_q1 = 12'(4095 - m_ramp);
            m_ramp = (m_ramp + 1) % 4096;
          end
          2'd2: begin
            e_i1 = 12'(m_lfsr % 4096);
            e_q1 = 12'(4095 - (m_lfsr % 4096));
            m_lfsr = ((m_lfsr << 1) | (((m_lfsr >> 14) ^ (m_lfsr >> 13)) & 1)) & 32'h7fff;
          end
          default: begin
            e_i1 = 0;
            e_q1 = 0;
          end
        endcase
        e_cnt = e_cnt + 1;
      end
      if (pat_wr) begin
        m_pat[0] = pat_a_i; m_pat[1] = pat_a_q; m_pat[2] = pat_b_i; m_pat[3] = pat_b_q;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1; enable = 0; mode = 2'd0; pat_wr = 0;
    pat_a_i = 0; pat_a_q = 0; pat_b_i = 0; pat_b_q = 0;
    repeat (3) tick();
    total++;
    if (dut1_obs !== 81'd0) begin
      bad++; $display("FAIL reset_outputs: got %h want 0", dut1_obs);
    end
    total++;
    if (dac_r1_mode !== 1'b1) begin
      bad++; $display("FAIL r1_mode: got %b want 1", dac_r1_mode);
    end
    $display("reset: outputs=%h r1_mode=%b", dut1_obs, dac_r1_mode);
  endtask

  task automatic test_alt_cadence();
    logic [11:0] want_i [3];
    logic [11:0] want_q [3];
    want_i[0] = DEF_A_I; want_i[1] = DEF_B_I; want_i[2] = DEF_A_I;
    want_q[0] = DEF_A_Q; want_q[1] = DEF_B_Q; want_q[2] = DEF_A_Q;
    rst = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      total++;
      if (dac_valid !== 1'b0) begin
        bad++; $display("FAIL idle_valid k=%0d: got %b want 0", k, dac_valid);
      end
    end
    enable = 1;
    for (int k = 0; k < 6; k++) begin
      tick();
      total++;
      if (dac_valid !== (k % 2 == 0)) begin
        bad++; $display("FAIL alt_cadence k=%0d: got %b want %b", k, dac_valid, (k % 2 == 0));
      end
      total++;
      if (dut1_obs !== exp1) begin
        bad++; $display("FAIL alt_model k=%0d: got %h want %h", k, dut1_obs, exp1);
      end
      if (k % 2 == 0) begin
        total++;
        if ({dac_data_i1, dac_data_q1} !== {want_i[k/2], want_q[k/2]}) begin
          bad++; $display("FAIL alt_value k=%0d: got %o/%o want %o/%o", k,
                          dac_data_i1, dac_data_q1, want_i[k/2], want_q[k/2]);
        end
        $display("alt: cycle %0d valid i1=%o q1=%o", 11 + k, dac_data_i1, dac_data_q1);
      end
    end
  endtask

  task automatic test_enable_drop();
    enable = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      total++;
      if (dac_valid !== 1'b0 || dut1_obs !== exp1) begin
        bad++; $display("FAIL drop_hold k=%0d: got %h want %h", k, dut1_obs, exp1);
      end
    end
    enable = 1;
    tick();
    total++;
    if ({dac_valid, dac_data_i1, dac_data_q1} !== {1'b1, DEF_B_I, DEF_B_Q}) begin
      bad++; $display("FAIL reenable_first: got %b %o/%o want 1 %o/%o",
                      dac_valid, dac_data_i1, dac_data_q1, DEF_B_I, DEF_B_Q);
    end
    tick();
    total++;
    if (dac_valid !== 1'b0 || dut1_obs !== exp1) begin
      bad++; $display("FAIL reenable_gap: got %h want %h", dut1_obs, exp1);
    end
    $display("enable_drop: resumed with i1=%o", dac_data_i1);
  endtask

  task automatic test_pat_wr();
    logic [11:0] n [4];
    logic [11:0] old_i, old_q;
    bit next_b;
    for (int i = 0; i < 4; i++) n[i] = 12'($urandom_range(0, 4095));
    for (int g = 0; g < 4 && !will_fire(); g++) tick();
    old_i  = m_use_b ? m_pat[2] : m_pat[0];
    old_q  = m_use_b ? m_pat[3] : m_pat[1];
    next_b = !m_use_b;
    pat_wr = 1; pat_a_i = n[0]; pat_a_q = n[1]; pat_b_i = n[2]; pat_b_q = n[3];
    tick();
    pat_wr = 0;
    total++;
    if ({dac_valid, dac_data_i1, dac_data_q1} !== {1'b1, old_i, old_q}) begin
      bad++; $display("FAIL patwr_old: got %b %o/%o want 1 %o/%o",
                      dac_valid, dac_data_i1, dac_data_q1, old_i, old_q);
    end
    for (int k = 0; k < 8; k++) begin
      tick();
      total++;
      if (dut1_obs !== exp1) begin
        bad++; $display("FAIL patwr_model k=%0d: got %h want %h", k, dut1_obs, exp1);
      end
      if (e_valid) begin
        total++;
        if ({dac_data_i1, dac_data_q1} !== (next_b ? {n[2], n[3]} : {n[0], n[1]})) begin
          bad++; $display("FAIL patwr_new k=%0d: got %o/%o want %o/%o", k, dac_data_i1, dac_data_q1,
                          next_b ? n[2] : n[0], next_b ? n[3] : n[1]);
        end
        next_b = !next_b;
      end
    end
    $display("pat_wr: new A=%o/%o B=%o/%o", n[0], n[1], n[2], n[3]);
  endtask

  task automatic test_reset_mid_ramp();
    mode = 2'd1;
    for (int k = 0; k < 6; k++) begin
      tick();
      total++;
      if (dut1_obs !== exp1) begin
        bad++; $display("FAIL ramp_pre k=%0d: got %h want %h", k, dut1_obs, exp1);
      end
    end
    for (int g = 0; g < 4 && !will_fire(); g++) tick();
    rst = 1;
    tick();
    total++;
    if (dut1_obs !== 81'd0) begin
      bad++; $display("FAIL rst_mid_ramp: got %h want 0", dut1_obs);
    end
    rst = 0;
    tick();
    total++;
    if (dut1_obs !== {1'b1, 12'h000, 12'hfff, 24'd0, 32'd1}) begin
      bad++; $display("FAIL ramp_after_rst: got %h want %h", dut1_obs,
                      {1'b1, 12'h000, 12'hfff, 24'd0, 32'd1});
    end
    $display("reset_mid_ramp: restart i1=%h cnt=%0d", dac_data_i1, sample_count);
  endtask

  task automatic test_ramp_wrap();
    rst = 1; tick(); rst = 0;
    mode = 2'd1; enable = 1;
    for (int k = 0; k < 8193; k++) begin
      tick();
      total++;
      if (dut1_obs !== exp1) begin
        bad++; $display("FAIL ramp_wrap k=%0d: got %h want %h", k, dut1_obs, exp1);
      end
      if (k == 8190) begin
        total++;
        if (dac_data_i1 !== 12'hfff) begin
          bad++; $display("FAIL ramp_top: got %h want fff", dac_data_i1);
        end
      end
    end
    total++;
    if ({dac_data_i1, sample_count} !== {12'h000, 32'd4097}) begin
      bad++; $display("FAIL ramp_end: got i1=%h cnt=%0d want i1=000 cnt=4097", dac_data_i1, sample_count);
    end
    $display("ramp_wrap: last i1=%h cnt=%0d", dac_data_i1, sample_count);
  endtask

  task automatic test_prbs();
    logic [11:0] first [8];
    int n;
    rst = 1; tick(); rst = 0;
    mode = 2'd2; enable = 1;
    for (int k = 0; k < 65549; k++) begin
      tick();
      total++;
      if (dut1_obs !== exp1) begin
        bad++; $display("FAIL prbs k=%0d: got %h want %h", k, dut1_obs, exp1);
      end
      if (k % 2 == 0) begin
        n = k / 2;
        if (n == 0) begin
          total++;
          if ({dac_data_i1, dac_data_q1} !== {12'hfff, 12'h000}) begin
            bad++; $display("FAIL prbs_first: got %h/%h want fff/000", dac_data_i1, dac_data_q1);
          end
        end
        if (n < 8) first[n] = e_i1;
        if (n >= 32767) begin
          total++;
          if (dac_data_i1 !== first[n-32767]) begin
            bad++; $display("FAIL prbs_repeat n=%0d: got %h want %h", n, dac_data_i1, first[n-32767]);
          end
        end
      end
    end
    $display("prbs: %0d samples, cnt=%0d", 32775, sample_count);
  endtask

  task automatic test_random();
    for (int k = 0; k < 1500; k++) begin
      rst    = ($urandom_range(0, 199) == 0);
      enable = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 7) == 0) mode = 2'($urandom_range(0, 3));
      pat_wr = ($urandom_range(0, 15) == 0);
      if (pat_wr) begin
        pat_a_i = 12'($urandom); pat_a_q = 12'($urandom);
        pat_b_i = 12'($urandom); pat_b_q = 12'($urandom);
      end
      tick();
      total++;
      if (dut1_obs !== exp1) begin
        bad++; $display("FAIL random k=%0d mode=%0d: got %h want %h", k, mode, dut1_obs, exp1);
      end
    end
    rst = 0; pat_wr = 0; enable = 0;
    $display("random: done, cnt=%0d", sample_count);
  endtask

  task automatic test_two_channel();
    logic [11:0] ei, eq;
    rst2 = 1; tick(); rst2 = 0;
    en2 = 1; mode2 = 2'd1;
    for (int k = 0; k < 12; k++) begin
      tick();
      ei = 12'(k / 4);
      eq = 12'(4095 - k / 4);
      total++;
      if ({v2, i1_2, q1_2, i2_2, q2_2, cnt2} !== {(k % 4 == 0), ei, eq, eq, ei, 32'(k / 4 + 1)}) begin
        bad++; $display("FAIL two_ch k=%0d: got %b %h %h %h %h %0d want %b %h %h %h %h %0d", k,
                        v2, i1_2, q1_2, i2_2, q2_2, cnt2, (k % 4 == 0), ei, eq, eq, ei, k / 4 + 1);
      end
    end
    total++;
    if (r1m2 !== 1'b0) begin
      bad++; $display("FAIL two_ch_r1_mode: got %b want 0", r1m2);
    end
    $display("two_channel: i1=%h q1=%h i2=%h q2=%h", i1_2, q1_2, i2_2, q2_2);
  endtask

  initial begin
    rst2 = 1; en2 = 0; mode2 = 2'd0;
    test_reset();
    test_alt_cadence();
    test_enable_drop();
    test_pat_wr();
    test_reset_mid_ramp();
    test_ramp_wrap();
    test_prbs();
    test_random();
    test_two_channel();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
